// File: rtl/core_pkg.sv
// Shared encodings for the execute stage: ALU op codes, writeback load code,
// multiplier FSM states and the EX/MEM pipeline register layout.
package core_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10,
    ALU_MUL   = 4'd11
  } alu_op_e;

  localparam logic [1:0] WB_LOAD = 2'b01;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_e;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [1:0]  wb_ctrl;
    logic        we_reg;
    logic        we_mem;
    logic [3:0]  ls_type;
  } exmem_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative 32x32 shift-add multiplier returning the low 32 product bits;
// 32 BUSY steps after a start, product valid combinationally on the last step.
module mul_iter
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        last_o,
  output logic [31:0] product_o
);

  mul_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] step_sum_s;

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
  assign step_sum_s = acc_q + (b_q[0] ? a_q : 32'd0);
  assign product_o  = step_sum_s;
  assign busy_o     = (state_q == MUL_BUSY);
  assign last_o     = (state_q == MUL_BUSY) && (cnt_q == 5'd31);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MUL_IDLE;
      cnt_q   <= 5'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      acc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  // Next-state logic; a flush abandons any partial product.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    case (state_q)
      MUL_IDLE: begin
        if (start_i && !flush_i) begin
          a_d     = a_i;
          b_d     = b_i;
          acc_d   = 32'd0;
          cnt_d   = 5'd0;
          state_d = MUL_BUSY;
        end else begin
          state_d = MUL_IDLE;
        end
      end
      MUL_BUSY: begin
        if (flush_i) begin
          acc_d   = 32'd0;
          cnt_d   = 5'd0;
          state_d = MUL_IDLE;
        end else begin
          acc_d   = step_sum_s;
          a_d     = {a_q[30:0], 1'b0};
          b_d     = {1'b0, b_q[31:1]};
          cnt_d   = cnt_q + 5'd1;
          state_d = (cnt_q == 5'd31) ? MUL_IDLE : MUL_BUSY;
        end
      end
      default: begin
        acc_d   = 32'd0;
        cnt_d   = 5'd0;
        state_d = MUL_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative multiply with
// upstream stall, and the EX/MEM pipeline register.
module ex_stage
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_X,
  input  logic [31:0] PC_E,
  input  logic [31:0] rdata1_E,
  input  logic [31:0] rdata2_E,
  input  logic [31:0] imm_E,
  input  logic [4:0]  rs1_E,
  input  logic [4:0]  rs2_E,
  input  logic [4:0]  rd_E,
  input  logic [3:0]  ALU_ctrl_E,
  input  logic        ALU_src1_E,
  input  logic        ALU_src2_E,
  input  logic [1:0]  wb_ctrl_E,
  input  logic        we_reg_E,
  input  logic        we_mem_E,
  input  logic [3:0]  ls_type_E,
  input  logic [4:0]  rd_W,
  input  logic        we_reg_W,
  input  logic [31:0] WB_data,
  output logic [31:0] alu_result_M,
  output logic [31:0] store_data_M,
  output logic [31:0] PC_M,
  output logic [4:0]  rd_M,
  output logic [1:0]  wb_ctrl_M,
  output logic        we_reg_M,
  output logic        we_mem_M,
  output logic [3:0]  ls_type_M,
  output logic        stall_ex
);

  exmem_t      exmem_q, exmem_d, exmem_pass_s;
  logic [31:0] fwd_a_s, fwd_b_s, src_a_s, src_b_s, alu_out_s;
  logic        mul_op_s, mul_busy_s, mul_last_s, stall_s;
  logic [31:0] mul_product_s;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_ADD:   r = a + b;
      ALU_SUB:   r = a - b;
      ALU_AND:   r = a & b;
      ALU_OR:    r = a | b;
      ALU_XOR:   r = a ^ b;
      ALU_SLL:   r = a << b[4:0];
      ALU_SRL:   r = a >> b[4:0];
      ALU_SRA:   r = $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:   r = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU:  r = {31'd0, (a < b)};
      ALU_PASSB: r = b;
      default:   r = 32'd0;
    endcase
    return r;
  endfunction

  // Forwarding: MEM wins over WB; a load in MEM has no data yet and is skipped.
  always_comb begin
    fwd_a_s = rdata1_E;
    if (exmem_q.we_reg && (exmem_q.rd != 5'd0) && (exmem_q.rd == rs1_E) &&
        (exmem_q.wb_ctrl != WB_LOAD)) begin
      fwd_a_s = exmem_q.alu_result;
    end else if (we_reg_W && (rd_W != 5'd0) && (rd_W == rs1_E)) begin
      fwd_a_s = WB_data;
    end else begin
      fwd_a_s = rdata1_E;
    end
  end

  // Same forwarding rule for the second operand, which is also the store data.
  always_comb begin
    fwd_b_s = rdata2_E;
    if (exmem_q.we_reg && (exmem_q.rd != 5'd0) && (exmem_q.rd == rs2_E) &&
        (exmem_q.wb_ctrl != WB_LOAD)) begin
      fwd_b_s = exmem_q.alu_result;
    end else if (we_reg_W && (rd_W != 5'd0) && (rd_W == rs2_E)) begin
      fwd_b_s = WB_data;
    end else begin
      fwd_b_s = rdata2_E;
    end
  end

  assign src_a_s   = ALU_src1_E ? PC_E : fwd_a_s;
  assign src_b_s   = ALU_src2_E ? imm_E : fwd_b_s;
  assign alu_out_s = alu_f(ALU_ctrl_E, src_a_s, src_b_s);
  assign mul_op_s  = (ALU_ctrl_E == ALU_MUL);

  mul_iter u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush_X),
    .start_i   (mul_op_s),
    .a_i       (src_a_s),
    .b_i       (src_b_s),
    .busy_o    (mul_busy_s),
    .last_o    (mul_last_s),
    .product_o (mul_product_s)
  );

  // Hold upstream while a multiply starts or is mid-flight; the final step does not stall.
  assign stall_s  = rst_n && !flush_X &&
                    ((!mul_busy_s && mul_op_s) || (mul_busy_s && !mul_last_s));
  assign stall_ex = stall_s;

  // EX/MEM next value: flush and stall insert bubbles, the last multiply step writes the product.
  always_comb begin
    exmem_pass_s            = '0;
    exmem_pass_s.store_data = fwd_b_s;
    exmem_pass_s.pc         = PC_E;
    exmem_pass_s.rd         = rd_E;
    exmem_pass_s.wb_ctrl    = wb_ctrl_E;
    exmem_pass_s.we_reg     = we_reg_E;
    exmem_pass_s.we_mem     = we_mem_E;
    exmem_pass_s.ls_type    = ls_type_E;
    exmem_d                 = '0;
    if (flush_X) begin
      exmem_d = '0;
    end else if (mul_last_s) begin
      exmem_d            = exmem_pass_s;
      exmem_d.alu_result = mul_product_s;
    end else if (stall_s) begin
      exmem_d = '0;
    end else begin
      exmem_d            = exmem_pass_s;
      exmem_d.alu_result = alu_out_s;
    end
  end

  // EX/MEM pipeline register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exmem_q <= '0;
    end else begin
      exmem_q <= exmem_d;
    end
  end

  assign alu_result_M = exmem_q.alu_result;
  assign store_data_M = exmem_q.store_data;
  assign PC_M         = exmem_q.pc;
  assign rd_M         = exmem_q.rd;
  assign wb_ctrl_M    = exmem_q.wb_ctrl;
  assign we_reg_M     = exmem_q.we_reg;
  assign we_mem_M     = exmem_q.we_mem;
  assign ls_type_M    = exmem_q.ls_type;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: reset, forwarding, ALU ops,
// multiply latency, flush and reset during a multiply.
module tb_ex_stage;

  logic        clk, rst_n, flush_X;
  logic [31:0] PC_E, rdata1_E, rdata2_E, imm_E;
  logic [4:0]  rs1_E, rs2_E, rd_E, rd_W;
  logic [3:0]  ALU_ctrl_E, ls_type_E;
  logic        ALU_src1_E, ALU_src2_E, we_reg_E, we_mem_E, we_reg_W;
  logic [1:0]  wb_ctrl_E;
  logic [31:0] WB_data;
  logic [31:0] alu_result_M, store_data_M, PC_M;
  logic [4:0]  rd_M;
  logic [1:0]  wb_ctrl_M;
  logic        we_reg_M, we_mem_M, stall_ex;
  logic [3:0]  ls_type_M;

  int checks_cnt;
  int errors_cnt;
  logic [31:0] exp_tab [16];

  ex_stage dut (
    .clk(clk), .rst_n(rst_n), .flush_X(flush_X),
    .PC_E(PC_E), .rdata1_E(rdata1_E), .rdata2_E(rdata2_E), .imm_E(imm_E),
    .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
    .ALU_ctrl_E(ALU_ctrl_E), .ALU_src1_E(ALU_src1_E), .ALU_src2_E(ALU_src2_E),
    .wb_ctrl_E(wb_ctrl_E), .we_reg_E(we_reg_E), .we_mem_E(we_mem_E), .ls_type_E(ls_type_E),
    .rd_W(rd_W), .we_reg_W(we_reg_W), .WB_data(WB_data),
    .alu_result_M(alu_result_M), .store_data_M(store_data_M), .PC_M(PC_M),
    .rd_M(rd_M), .wb_ctrl_M(wb_ctrl_M), .we_reg_M(we_reg_M), .we_mem_M(we_mem_M),
    .ls_type_M(ls_type_M), .stall_ex(stall_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    flush_X = 1'b0; PC_E = 32'd0; rdata1_E = 32'd0; rdata2_E = 32'd0; imm_E = 32'd0;
    rs1_E = 5'd0; rs2_E = 5'd0; rd_E = 5'd0; ALU_ctrl_E = 4'd0;
    ALU_src1_E = 1'b0; ALU_src2_E = 1'b0; wb_ctrl_E = 2'd0; we_reg_E = 1'b0;
    we_mem_E = 1'b0; ls_type_E = 4'd0; rd_W = 5'd0; we_reg_W = 1'b0; WB_data = 32'd0;
  endtask

  // Register-writing op with immediate second operand.
  task automatic op_imm(input logic [3:0] op, input logic [4:0] rs1, input logic [31:0] a,
                        input logic [31:0] imm, input logic [4:0] rd);
    ALU_ctrl_E = op; rs1_E = rs1; rdata1_E = a; imm_E = imm; ALU_src2_E = 1'b1;
    ALU_src1_E = 1'b0; rs2_E = 5'd0; rd_E = rd; we_reg_E = 1'b1; we_mem_E = 1'b0;
    wb_ctrl_E = 2'b00;
  endtask

  initial begin
    int n;
    checks_cnt = 0;
    errors_cnt = 0;
    exp_tab[0]  = 32'hF000000C; exp_tab[1]  = 32'hF0000004; exp_tab[2]  = 32'h00000000;
    exp_tab[3]  = 32'hF000000C; exp_tab[4]  = 32'hF000000C; exp_tab[5]  = 32'h00000080;
    exp_tab[6]  = 32'h0F000000; exp_tab[7]  = 32'hFF000000; exp_tab[8]  = 32'h00000001;
    exp_tab[9]  = 32'h00000000; exp_tab[10] = 32'h00000004; exp_tab[11] = 32'h00000000;
    exp_tab[12] = 32'h00000000; exp_tab[13] = 32'h00000000; exp_tab[14] = 32'h00000000;
    exp_tab[15] = 32'h00000000;

    clear_in();
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_alu", alu_result_M, 32'd0);
    chk("rst_store", store_data_M, 32'd0);
    chk("rst_pc", PC_M, 32'd0);
    chk("rst_rd", {27'd0, rd_M}, 32'd0);
    chk("rst_we", {30'd0, we_reg_M, we_mem_M}, 32'd0);
    chk("rst_stall", {31'd0, stall_ex}, 32'd0);
    rst_n = 1'b1;

    // ADD 5 + imm 7 -> 12
    op_imm(4'd0, 5'd1, 32'd5, 32'd7, 5'd3); PC_E = 32'h100;
    tick();
    chk("add_res", alu_result_M, 32'd12);
    chk("add_rd", {27'd0, rd_M}, 32'd3);
    chk("add_we", {31'd0, we_reg_M}, 32'd1);
    chk("add_pc", PC_M, 32'h100);

    // x1=10 in MEM, x1=20 in WB; MEM wins
    op_imm(4'd0, 5'd2, 32'd3, 32'd7, 5'd1);
    tick();
    rd_W = 5'd1; we_reg_W = 1'b1; WB_data = 32'd20;
    op_imm(4'd1, 5'd1, 32'd0, 32'd4, 5'd5);
    tick();
    chk("fwd_mem_pri", alu_result_M, 32'd6);
    op_imm(4'd0, 5'd1, 32'd0, 32'd0, 5'd6);
    tick();
    chk("fwd_wb", alu_result_M, 32'd20);

    // Load in MEM is not forwarded; WB value used
    op_imm(4'd0, 5'd2, 32'd3, 32'd7, 5'd1); wb_ctrl_E = 2'b01;
    tick();
    op_imm(4'd0, 5'd1, 32'd0, 32'd0, 5'd6);
    tick();
    chk("fwd_skip_load", alu_result_M, 32'd20);

    // Store: rs2 forwarded from MEM (x6=20) becomes store data
    op_imm(4'd0, 5'd12, 32'h1000, 32'd0, 5'd0);
    ALU_src2_E = 1'b0; rs2_E = 5'd6; rdata2_E = 32'd0;
    we_reg_E = 1'b0; we_mem_E = 1'b1; ls_type_E = 4'h2;
    tick();
    chk("st_addr", alu_result_M, 32'h1014);
    chk("st_data", store_data_M, 32'd20);
    chk("st_ctrl", {28'd0, we_mem_M, we_reg_M, ls_type_M[1:0]}, 32'h0000000A);
    we_reg_W = 1'b0; ls_type_E = 4'd0;

    // rd_M=0 never forwards
    op_imm(4'd0, 5'd13, 32'd9, 32'd0, 5'd0);
    tick();
    op_imm(4'd0, 5'd0, 32'h55, 32'd0, 5'd4);
    tick();
    chk("no_fwd_x0", alu_result_M, 32'h55);

    // ALU op table, operands from registers
    for (int i = 0; i < 16; i++) begin
      if (i != 11) begin
        op_imm(i[3:0], 5'd10, 32'hF0000008, 32'd0, 5'd8);
        ALU_src2_E = 1'b0; rs2_E = 5'd11; rdata2_E = 32'd4;
        tick();
        chk($sformatf("alu_op%0d", i), alu_result_M, exp_tab[i]);
      end
    end

    // MUL 0xFFFFFFFF * 3: 32 stalled cycles, result on edge 33
    op_imm(4'd11, 5'd10, 32'hFFFFFFFF, 32'd3, 5'd7);
    #1;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("mul_stall%0d", i), {31'd0, stall_ex}, 32'd1);
      tick();
      chk($sformatf("mul_bubble%0d", i), {26'd0, we_reg_M, rd_M}, 32'd0);
    end
    chk("mul_last_nostall", {31'd0, stall_ex}, 32'd0);
    tick();
    chk("mul_res", alu_result_M, 32'hFFFFFFFD);
    chk("mul_rd", {27'd0, rd_M}, 32'd7);
    chk("mul_we", {31'd0, we_reg_M}, 32'd1);
    clear_in();
    tick();

    // Flush at cnt=10
    op_imm(4'd11, 5'd10, 32'd2, 32'd3, 5'd7);
    for (int i = 0; i < 11; i++) tick();
    flush_X = 1'b1;
    #1;
    chk("flush_stall", {31'd0, stall_ex}, 32'd0);
    tick();
    chk("flush_bubble", {25'd0, we_reg_M, we_mem_M, rd_M}, 32'd0);
    chk("flush_wb", {30'd0, wb_ctrl_M}, 32'd0);
    flush_X = 1'b0;
    op_imm(4'd0, 5'd1, 32'd5, 32'd7, 5'd3);
    #1;
    chk("flush_idle", {31'd0, stall_ex}, 32'd0);
    tick();
    chk("flush_next_add", alu_result_M, 32'd12);
    chk("flush_next_we", {31'd0, we_reg_M}, 32'd1);

    // Reset at cnt=20, then a fresh MUL 6*7
    op_imm(4'd11, 5'd10, 32'd5, 32'd5, 5'd7);
    for (int i = 0; i < 21; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mul_stall", {31'd0, stall_ex}, 32'd0);
    tick();
    chk("rst_mul_alu", alu_result_M, 32'd0);
    chk("rst_mul_ctrl", {25'd0, we_reg_M, we_mem_M, rd_M}, 32'd0);
    rst_n = 1'b1;
    op_imm(4'd11, 5'd10, 32'd6, 32'd7, 5'd9);
    n = 0;
    while (n < 40 && we_reg_M !== 1'b1) begin
      tick();
      n++;
    end
    chk("mul2_edges", n, 32'd33);
    chk("mul2_res", alu_result_M, 32'd42);
    chk("mul2_rd", {27'd0, rd_M}, 32'd9);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, synchronous, active-low.
REQ-003 flush_X  in  1  kill the instruction in EX; abort any multiply.
REQ-004 PC_E, rdata1_E, rdata2_E, imm_E  in  32 each  ID/EX operands.
REQ-005 rs1_E, rs2_E, rd_E  in  5 each  register indices.
REQ-006 ALU_ctrl_E  in  4  ALU op; ALU_src1_E  in  1  1 = PC else rs1; ALU_src2_E  in  1  1 = imm else rs2.
REQ-007 wb_ctrl_E  in  2  (2'b01 = load), we_reg_E, we_mem_E  in  1 each, ls_type_E  in  4  pass-through controls.
REQ-008 rd_W  in  5, we_reg_W  in  1, WB_data  in  32  writeback-stage forwarding source.
REQ-009 alu_result_M, store_data_M, PC_M  out  32 each; rd_M  out  5; wb_ctrl_M  out  2; we_reg_M, we_mem_M  out  1 each; ls_type_M  out  4  EX/MEM register.
REQ-010 stall_ex  out  1  when high, the upstream stage SHALL hold ID/EX and the PC.

Function
REQ-011 Operand A forwarding: if we_reg_M, rd_M!=0, rd_M==rs1_E and wb_ctrl_M!=load, use alu_result_M; else if we_reg_W, rd_W!=0 and rd_W==rs1_E, use WB_data; else use rdata1_E. MEM has priority.
REQ-012 Operand B forwarding uses the same rule with rs2_E; the forwarded rs2 value is the store data.
REQ-013 srcA = ALU_src1_E ? PC_E : fwdA; srcB = ALU_src2_E ? imm_E : fwdB.
REQ-014 ALU ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 PASSB, 11 MUL; codes 12-15 give result 0.
REQ-015 Shift amount is srcB[4:0]; SLT/SLTU give a zero-extended 0/1; all arithmetic wraps modulo 2^32.
REQ-016 Non-MUL ops: single cycle; the EX/MEM register captures result, fwdB, PC_E, rd_E and controls on the next edge.
REQ-017 MUL FSM states IDLE and BUSY; 5-bit counter cnt.
REQ-018 IDLE with ALU_ctrl_E==MUL and !flush_X: latch srcA/srcB, clear the accumulator, set cnt=0, go to BUSY, and load a bubble into EX/MEM.
REQ-019 BUSY: perform one shift-add step per cycle (low 32 bits of the product, unsigned and signed identical) and increment cnt.
REQ-020 BUSY with cnt==31: the edge writes the product into alu_result_M with the MUL's rd/controls and returns to IDLE.
REQ-021 stall_ex = (IDLE && MUL && !flush_X) || (BUSY && cnt!=31); the MUL result reaches EX/MEM 33 edges after the MUL first appears in EX.
REQ-022 While stall_ex is high, EX/MEM SHALL receive a bubble (we_reg_M=0, we_mem_M=0, rd_M=0, wb_ctrl_M=0).
REQ-023 flush_X in any state SHALL load a bubble into EX/MEM, force IDLE, and drive stall_ex low that cycle.
REQ-024 flush_X has priority over a MUL start and over MUL completion.

Reset
REQ-025 rst_n low at an edge SHALL clear all EX/MEM outputs to 0, the FSM to IDLE, and cnt and the accumulator to 0; stall_ex is 0 during reset.
REQ-026 Reset during BUSY SHALL discard the partial product; no write reaches EX/MEM.

Structure
REQ-027 ALU op codes, the wb_ctrl load code and the FSM state encoding SHALL live in shared package core_pkg.
REQ-028 The iterative multiplier SHALL be a sub-module mul_iter (start, a, b, busy, last, product); forwarding and the ALU stay in ex_stage.

Verification
REQ-029 ADD, srcA=5, srcB=imm 7, rd=3, we_reg=1 -> next edge alu_result_M=12, rd_M=3, we_reg_M=1.
REQ-030 Back-to-back: x1=10 in M (non-load), x1=20 in W, SUB rs1=1 with rdata1_E=0, rs2 imm 4 -> alu_result_M=6 (MEM priority).
REQ-031 rd_M=0 with we_reg_M=1 and rs1_E=0 -> no forwarding, rdata1_E is used.
REQ-032 MUL 0xFFFFFFFF * 3 -> stall_ex high for 32 cycles, bubbles in EX/MEM, then alu_result_M=0xFFFFFFFD on edge 33, stall_ex low.
REQ-033 flush_X at cnt=10 -> stall_ex low immediately, EX/MEM holds a bubble, FSM in IDLE; the next ADD proceeds normally.
REQ-034 rst_n low at cnt=20 -> all outputs 0; after release, a new MUL 6*7 gives 42.
